// File: rtl/adc_serial_source_if.sv
// Serial link between the emulated ADC (slave side) and the receiving driver (master side).
interface adc_serial_source_if;
  logic SPI_SCK;
  logic AD_CONV;
  logic ADC_OUT;

  modport master (output SPI_SCK, output AD_CONV, input ADC_OUT);
  modport slave  (input SPI_SCK, input AD_CONV, output ADC_OUT);
endinterface

// File: rtl/adc_serial_source.sv
// LTC1407A-1 style serial source: frames two samples per AD_CONV rise, shifts MSB-first on SCK falls.
// Define ADC_SRC_TRI_EN to build the ramp as a clamped triangle instead of a wrapping sawtooth.
module adc_serial_source #(
  parameter int DATA_W    = 14,
  parameter int LEAD_BITS = 2,
  parameter int FRAME_LEN = 3*LEAD_BITS + 2*DATA_W,
  parameter int STEP      = 1
) (
  input  logic                     CLK_50M,
  input  logic                     RST_N,
  adc_serial_source_if.slave       link,
  input  logic                     enable,
  input  logic                     src_sel,
  input  logic signed [DATA_W-1:0] Va_in,
  input  logic signed [DATA_W-1:0] Vb_in,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     overrun,
  output logic [15:0]              frame_cnt
);

  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam logic [DATA_W-1:0]        STEP_V = DATA_W'(STEP);
  localparam logic signed [DATA_W-1:0] MIN_N  = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] MAX_N  = {1'b0, {(DATA_W-1){1'b1}}};

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                     state_q, state_d;
  logic                       sck_q, sck_qq, conv_q, conv_qq;
  logic [FRAME_LEN-1:0]       shreg_q, shreg_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       done_q, done_d;
  logic                       ovr_q, ovr_d;
  logic [15:0]                fcnt_q, fcnt_d;
  logic signed [DATA_W-1:0]   ramp_q, ramp_d;
  logic signed [DATA_W-1:0]   a_sel, b_sel;
  logic                       sck_fall, conv_rise;

  function automatic logic signed [DATA_W-1:0] neg_sat(input logic signed [DATA_W-1:0] v);
    return (v == MIN_N) ? MAX_N : -v;
  endfunction

`ifdef ADC_SRC_TRI_EN
  localparam logic signed [DATA_W+1:0] STEP_W = {2'b00, STEP_V};
  localparam logic signed [DATA_W+1:0] MAX_W  = {2'b00, MAX_N};
  localparam logic signed [DATA_W+1:0] MIN_W  = {2'b11, MIN_N};

  logic                     dir_q, dir_d;
  logic signed [DATA_W+1:0] ramp_ext, tri_nxt;

  function automatic logic signed [DATA_W-1:0] clamp_w(input logic signed [DATA_W+1:0] v);
    if (v > MAX_W) return MAX_N;
    if (v < MIN_W) return MIN_N;
    return $signed(v[DATA_W-1:0]);
  endfunction

  // dir_q=1 means descending; the flip happens on the frame that reaches a limit
  assign ramp_ext = {{2{ramp_q[DATA_W-1]}}, ramp_q};
  assign tri_nxt  = dir_q ? (ramp_ext - STEP_W) : (ramp_ext + STEP_W);
`endif

  assign sck_fall  = sck_qq & ~sck_q;
  assign conv_rise = ~conv_qq & conv_q;
  assign a_sel     = src_sel ? ramp_q : Va_in;
  assign b_sel     = src_sel ? neg_sat(ramp_q) : Vb_in;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    ovr_d   = ovr_q;
    fcnt_d  = fcnt_q;
    ramp_d  = ramp_q;
`ifdef ADC_SRC_TRI_EN
    dir_d   = dir_q;
`endif
    case (state_q)
      IDLE: begin
        if (conv_rise && enable) begin
          state_d = SHIFT;
          shreg_d = {{LEAD_BITS{1'b0}}, a_sel, {LEAD_BITS{1'b0}}, b_sel, {LEAD_BITS{1'b0}}};
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (conv_rise) ovr_d = 1'b1;
        if (sck_fall) begin
          shreg_d = shreg_q << 1;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
            state_d = IDLE;
            shreg_d = '0;
            done_d  = 1'b1;
            fcnt_d  = fcnt_q + 16'd1;
`ifdef ADC_SRC_TRI_EN
            ramp_d  = clamp_w(tri_nxt);
            if (!dir_q && tri_nxt >= MAX_W)     dir_d = 1'b1;
            else if (dir_q && tri_nxt <= MIN_W) dir_d = 1'b0;
`else
            ramp_d  = ramp_q + $signed(STEP_V);
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      sck_q   <= 1'b0;
      sck_qq  <= 1'b0;
      conv_q  <= 1'b0;
      conv_qq <= 1'b0;
      shreg_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      fcnt_q  <= '0;
      ramp_q  <= '0;
`ifdef ADC_SRC_TRI_EN
      dir_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sck_q   <= link.SPI_SCK;
      sck_qq  <= sck_q;
      conv_q  <= link.AD_CONV;
      conv_qq <= conv_q;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      fcnt_q  <= fcnt_d;
      ramp_q  <= ramp_d;
`ifdef ADC_SRC_TRI_EN
      dir_q   <= dir_d;
`endif
    end
  end

  assign link.ADC_OUT = shreg_q[FRAME_LEN-1];
  assign busy         = (state_q == SHIFT);
  assign frame_done   = done_q;
  assign overrun      = ovr_q;
  assign frame_cnt    = fcnt_q;

endmodule

// File: tb/tb_adc_serial_source.sv
// Bench for adc_serial_source: two instances (ramp STEP=1 and STEP=8192) driven from one serial master.
module tb_adc_serial_source;
  localparam int DW     = 14;
  localparam int FL     = 34;
  localparam int STEP_A = 1;
  localparam int STEP_B = 8192;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic src_sel = 1'b0;
  logic signed [DW-1:0] va = '0, vb = '0;
  logic busy_a, done_a, ovr_a, busy_b, done_b, ovr_b;
  logic [15:0] fc_a, fc_b;

  always #5 clk = ~clk;

  adc_serial_source_if lnk_a();
  adc_serial_source_if lnk_b();
  assign lnk_b.SPI_SCK = lnk_a.SPI_SCK;
  assign lnk_b.AD_CONV = lnk_a.AD_CONV;

  adc_serial_source #(.STEP(STEP_A)) u_dut_a (
    .CLK_50M(clk), .RST_N(rst_n), .link(lnk_a), .enable(enable), .src_sel(src_sel),
    .Va_in(va), .Vb_in(vb), .busy(busy_a), .frame_done(done_a), .overrun(ovr_a), .frame_cnt(fc_a));

  adc_serial_source #(.STEP(STEP_B)) u_dut_b (
    .CLK_50M(clk), .RST_N(rst_n), .link(lnk_b), .enable(enable), .src_sel(src_sel),
    .Va_in(va), .Vb_in(vb), .busy(busy_b), .frame_done(done_b), .overrun(ovr_b), .frame_cnt(fc_b));

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt_a = 0, done_cnt_b = 0;
  int ramp_m [2] = '{0, 0};
  int dir_m  [2] = '{0, 0};
  int fc_m  = 0;
  bit ovr_m = 1'b0;
  logic [FL-1:0] last_cap_a;

  always @(negedge clk) begin
    if (done_a) done_cnt_a++;
    if (done_b) done_cnt_b++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int wrap14(input int v);
    int r;
    r = v & 16383;
    if (r >= 8192) r -= 16384;
    return r;
  endfunction

  function automatic int neg_sat_m(input int a);
    return (a == -8192) ? 8191 : -a;
  endfunction

  function automatic logic [FL-1:0] frame_bits(input int a, input int b);
    logic [DW-1:0] av, bv;
    av = a[DW-1:0];
    bv = b[DW-1:0];
    return {2'b00, av, 2'b00, bv, 2'b00};
  endfunction

  task automatic advance_ramp(input int idx, input int step);
    int n;
`ifdef ADC_SRC_TRI_EN
    if (dir_m[idx] == 0) begin
      n = ramp_m[idx] + step;
      if (n >= 8191) begin n = 8191; dir_m[idx] = 1; end
    end else begin
      n = ramp_m[idx] - step;
      if (n <= -8192) begin n = -8192; dir_m[idx] = 0; end
    end
`else
    n = wrap14(ramp_m[idx] + step);
`endif
    ramp_m[idx] = n;
  endtask

  task automatic model_reset();
    ramp_m = '{0, 0};
    dir_m  = '{0, 0};
    fc_m   = 0;
    ovr_m  = 1'b0;
  endtask

  // One frame: conv pulse, 34 SCK falls, capture bit k after k falls; optional events at fall k.
  task automatic do_frame(input bit sel, input logic [DW-1:0] a_in, input logic [DW-1:0] b_in,
                          input int ovr_at, input int en_off_at, input int rst_at);
    logic [FL-1:0] exp_a, exp_b, cap_a, cap_b;
    int a_s, b_s, da0, db0;
    bit aborted;
    aborted = 1'b0;
    src_sel = sel;
    va = a_in;
    vb = b_in;
    a_s = $signed(a_in);
    b_s = $signed(b_in);
    exp_a = sel ? frame_bits(ramp_m[0], neg_sat_m(ramp_m[0])) : frame_bits(a_s, b_s);
    exp_b = sel ? frame_bits(ramp_m[1], neg_sat_m(ramp_m[1])) : frame_bits(a_s, b_s);
    da0 = done_cnt_a;
    db0 = done_cnt_b;
    lnk_a.AD_CONV = 1'b1;
    wclk(3);
    lnk_a.AD_CONV = 1'b0;
    wclk(3);
    check("busy_load", 64'(busy_a), 64'(1));
    cap_a = '0;
    cap_b = '0;
    cap_a[FL-1] = lnk_a.ADC_OUT;
    cap_b[FL-1] = lnk_b.ADC_OUT;
    va = DW'($urandom);
    vb = DW'($urandom);
    src_sel = ~sel;
    for (int k = 1; k <= FL; k++) begin
      lnk_a.SPI_SCK = 1'b1;
      wclk(3);
      lnk_a.SPI_SCK = 1'b0;
      if (k == ovr_at) begin
        lnk_a.AD_CONV = 1'b1;
        ovr_m = 1'b1;
      end
      wclk(3);
      lnk_a.AD_CONV = 1'b0;
      if (k == en_off_at) enable = 1'b0;
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_mid_out", 64'({lnk_a.ADC_OUT, lnk_b.ADC_OUT}), 64'(0));
        check("rst_mid_busy", 64'({busy_a, busy_b}), 64'(0));
        wclk(2);
        rst_n = 1'b1;
        model_reset();
        aborted = 1'b1;
        break;
      end
      if (k < FL) begin
        cap_a[FL-1-k] = lnk_a.ADC_OUT;
        cap_b[FL-1-k] = lnk_b.ADC_OUT;
      end
    end
    if (!aborted) begin
      fc_m = (fc_m + 1) & 16'hFFFF;
      advance_ramp(0, STEP_A);
      advance_ramp(1, STEP_B);
      last_cap_a = cap_a;
      check("frame_a", 64'(cap_a), 64'(exp_a));
      check("frame_b", 64'(cap_b), 64'(exp_b));
      check("end_idle", 64'({busy_a, busy_b, lnk_a.ADC_OUT, lnk_b.ADC_OUT}), 64'(0));
      check("fcnt_a", 64'(fc_a), 64'(fc_m));
      check("fcnt_b", 64'(fc_b), 64'(fc_m));
      check("done_pulses", 64'({16'(done_cnt_a - da0), 16'(done_cnt_b - db0)}), 64'({16'd1, 16'd1}));
      check("overrun", 64'({ovr_a, ovr_b}), 64'({ovr_m, ovr_m}));
    end
    wclk(2);
  endtask

  initial begin
    int fc_hold;
    lnk_a.SPI_SCK = 1'b0;
    lnk_a.AD_CONV = 1'b0;

    // reset held with activity on the link
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      lnk_a.SPI_SCK = ~lnk_a.SPI_SCK;
      lnk_a.AD_CONV = ~lnk_a.AD_CONV;
      wclk(3);
    end
    lnk_a.SPI_SCK = 1'b0;
    lnk_a.AD_CONV = 1'b0;
    wclk(2);
    check("rst_outs", 64'({lnk_a.ADC_OUT, busy_a, done_a, ovr_a}), 64'(0));
    check("rst_fcnt", 64'({fc_a, fc_b}), 64'(0));
    rst_n = 1'b1;
    wclk(10);
    check("post_rst_outs", 64'({lnk_a.ADC_OUT, busy_a, done_a, ovr_a, busy_b, ovr_b}), 64'(0));

    // fixed parallel frame
    do_frame(1'b0, 14'h1555, 14'h2AAA, 0, 0, 0);
    check("t2_bits", 64'(last_cap_a), 64'(34'b00_01010101010101_00_10101010101010_00));

    // SCK activity while idle
    for (int i = 0; i < 4; i++) begin
      lnk_a.SPI_SCK = 1'b1; wclk(3);
      lnk_a.SPI_SCK = 1'b0; wclk(3);
      check("idle_sck", 64'({lnk_a.ADC_OUT, busy_a, lnk_b.ADC_OUT, busy_b}), 64'(0));
    end

    // ramp frames, including wrap and saturation on the STEP=8192 instance
    for (int i = 0; i < 5; i++) do_frame(1'b1, DW'($urandom), DW'($urandom), 0, 0, 0);

    // overrun mid-frame
    do_frame(1'b0, DW'($urandom), DW'($urandom), 10, 0, 0);

    // reset mid-frame, then a clean frame
    do_frame(1'b1, DW'($urandom), DW'($urandom), 0, 0, 20);
    check("rst_clears", 64'({ovr_a, fc_a, fc_b}), 64'(0));
    do_frame(1'b1, DW'($urandom), DW'($urandom), 0, 0, 0);

    // conversion strobe coincident with the final fall
    do_frame(1'b0, DW'($urandom), DW'($urandom), FL, 0, 0);

    // enable low: strobe ignored; dropping enable mid-frame lets the frame finish
    enable = 1'b0;
    fc_hold = fc_m;
    lnk_a.AD_CONV = 1'b1; wclk(3);
    lnk_a.AD_CONV = 1'b0; wclk(3);
    check("en0_busy", 64'({busy_a, busy_b}), 64'(0));
    check("en0_fcnt", 64'(fc_a), 64'(fc_hold));
    enable = 1'b1;
    do_frame(1'b1, DW'($urandom), DW'($urandom), 0, 5, 0);
    lnk_a.AD_CONV = 1'b1; wclk(3);
    lnk_a.AD_CONV = 1'b0; wclk(3);
    check("en_off_busy", 64'({busy_a, busy_b}), 64'(0));
    enable = 1'b1;

    // randomized frames
    for (int i = 0; i < 16; i++)
      do_frame(1'($urandom), DW'($urandom), DW'($urandom), 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
